// File: rtl/perf_monitor_if.sv
// Trace stream port of perf_monitor: one captured data-memory store per beat,
// valid/ready handshake. The monitor drives the master side, the consumer the slave side.
interface perf_monitor_if #(
  parameter int WIDTH    = 32,
  parameter int CNTBITS  = 32,
  parameter int ADDRBITS = 16
);
  logic                trace_valid;
  logic                trace_ready;
  logic [ADDRBITS-1:0] trace_addr;
  logic [WIDTH-1:0]    trace_data;
  logic [CNTBITS-1:0]  trace_cycle;
  logic [CNTBITS-1:0]  trace_stall;

  modport master (
    output trace_valid, trace_addr, trace_data, trace_cycle, trace_stall,
    input  trace_ready
  );

  modport slave (
    input  trace_valid, trace_addr, trace_data, trace_cycle, trace_stall,
    output trace_ready
  );
endinterface

// File: rtl/perf_monitor.sv
// Performance and store-trace monitor for the pipelined MIPS core.
// Counts RUN cycles, fetch-stall cycles and NEVENTS generic events, and captures
// every data-memory write into a first-word-fall-through trace FIFO.
// Build option: define PERF_SATURATE_EN to make counters and stamps stick at
// all-ones instead of wrapping.
//
//   state | meaning
//   IDLE  | waiting for start, counters hold
//   RUN   | counting, stores captured into the trace FIFO
//   DONE  | halted, counters hold, FIFO still drains
module perf_monitor #(
  parameter int WIDTH       = 32,
  parameter int CNTBITS     = 32,
  parameter int NEVENTS     = 4,
  parameter int ADDRBITS    = 16,
  parameter int TRACE_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          halt,
  input  logic                          clear,
  input  logic                          stall_f,
  input  logic [NEVENTS-1:0]            event_in,
  input  logic                          memwrite,
  input  logic [WIDTH-1:0]              aluout,
  input  logic [WIDTH-1:0]              writedata,
  output logic                          running,
  output logic [CNTBITS-1:0]            cycle_count,
  output logic [CNTBITS-1:0]            stall_count,
  output logic [NEVENTS*CNTBITS-1:0]    event_count,
  perf_monitor_if.master                trace,
  output logic [$clog2(TRACE_DEPTH):0]  trace_level,
  output logic                          trace_ovf
);

  localparam int PTRBITS = $clog2(TRACE_DEPTH);
  localparam int LVLBITS = PTRBITS + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [CNTBITS-1:0]              cyc_q;
  logic [CNTBITS-1:0]              stl_q;
  logic [NEVENTS-1:0][CNTBITS-1:0] ev_q;

  logic [PTRBITS-1:0] wr_ptr, rd_ptr;
  logic [LVLBITS-1:0] level_q;
  logic               ovf_q;

  logic [ADDRBITS-1:0] mem_addr [TRACE_DEPTH];
  logic [WIDTH-1:0]    mem_data [TRACE_DEPTH];
  logic [CNTBITS-1:0]  mem_cyc  [TRACE_DEPTH];
  logic [CNTBITS-1:0]  mem_stl  [TRACE_DEPTH];

  logic fifo_valid, fifo_full, push_req, push, pop, drop;

  // Only the low ADDRBITS of the store address are traced; the rest is tapped but unused.
  logic unused_addr_hi;
  assign unused_addr_hi = ^aluout;

  function automatic logic [CNTBITS-1:0] bump(input logic [CNTBITS-1:0] v, input logic en);
`ifdef PERF_SATURATE_EN
    return (en && (v != '1)) ? v + CNTBITS'(1) : v;
`else
    return v + CNTBITS'(en);
`endif
  endfunction

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next state: clear wins from anywhere, start only from IDLE, halt only from RUN.
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (start) state_d = ST_RUN;
        ST_RUN:  if (halt)  state_d = ST_DONE;
        default: state_d = state_q;
      endcase
    end
  end

  assign running = (state_q == ST_RUN);

  // Counters advance on every RUN edge, including the one where halt is sampled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_q <= '0;
      stl_q <= '0;
      ev_q  <= '0;
    end else if (clear) begin
      cyc_q <= '0;
      stl_q <= '0;
      ev_q  <= '0;
    end else if (running) begin
      cyc_q <= bump(cyc_q, 1'b1);
      stl_q <= bump(stl_q, stall_f);
      for (int i = 0; i < NEVENTS; i++) ev_q[i] <= bump(ev_q[i], event_in[i]);
    end
  end

  assign cycle_count = cyc_q;
  assign stall_count = stl_q;
  assign event_count = ev_q;

  assign fifo_valid = (level_q != '0);
  assign fifo_full  = (level_q == LVLBITS'(TRACE_DEPTH));
  assign push_req   = memwrite & running & ~clear;
  assign pop        = fifo_valid & trace.trace_ready & ~clear;
  // A pop on the same edge frees the slot, so a full FIFO still accepts the store.
  assign push       = push_req & (~fifo_full | pop);
  assign drop       = push_req & fifo_full & ~pop;

  // FIFO pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
    end else if (clear) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTRBITS'(1);
      if (pop)  rd_ptr <= rd_ptr + PTRBITS'(1);
      case ({push, pop})
        2'b10:   level_q <= level_q + LVLBITS'(1);
        2'b01:   level_q <= level_q - LVLBITS'(1);
        default: level_q <= level_q;
      endcase
      if (drop) ovf_q <= 1'b1;
    end
  end

  // Trace storage; stamps are the counter values before this edge's increment.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[wr_ptr] <= aluout[ADDRBITS-1:0];
      mem_data[wr_ptr] <= writedata;
      mem_cyc[wr_ptr]  <= cyc_q;
      mem_stl[wr_ptr]  <= stl_q;
    end
  end

  // Payload is forced to zero when empty so reset and drained states read cleanly.
  assign trace.trace_valid = fifo_valid;
  assign trace.trace_addr  = fifo_valid ? mem_addr[rd_ptr] : '0;
  assign trace.trace_data  = fifo_valid ? mem_data[rd_ptr] : '0;
  assign trace.trace_cycle = fifo_valid ? mem_cyc[rd_ptr]  : '0;
  assign trace.trace_stall = fifo_valid ? mem_stl[rd_ptr]  : '0;
  assign trace_level       = level_q;
  assign trace_ovf         = ovf_q;

endmodule

// File: tb/tb_perf_monitor.sv
module tb_perf_monitor;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 0, halt = 0, clear = 0, stall_f = 0, memwrite = 0, ready = 0;
  logic [3:0]  ev = '0;
  logic [31:0] aluout = '0, writedata = '0;

  logic         running, running2;
  logic [31:0]  cycle_count, stall_count;
  logic [127:0] event_count;
  logic [3:0]   level, level2;
  logic         ovf, ovf2;
  logic [3:0]   cycle2, stall2;
  logic [15:0]  event2;

  perf_monitor_if #(.WIDTH(32), .CNTBITS(32), .ADDRBITS(16)) tif ();
  perf_monitor_if #(.WIDTH(32), .CNTBITS(4),  .ADDRBITS(16)) tif2 ();
  assign tif.trace_ready  = ready;
  assign tif2.trace_ready = 1'b1;

  perf_monitor #(.WIDTH(32), .CNTBITS(32), .NEVENTS(4), .ADDRBITS(16), .TRACE_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .halt(halt), .clear(clear), .stall_f(stall_f),
    .event_in(ev), .memwrite(memwrite), .aluout(aluout), .writedata(writedata),
    .running(running), .cycle_count(cycle_count), .stall_count(stall_count),
    .event_count(event_count), .trace(tif), .trace_level(level), .trace_ovf(ovf));

  perf_monitor #(.WIDTH(32), .CNTBITS(4), .NEVENTS(4), .ADDRBITS(16), .TRACE_DEPTH(DEPTH)) dut2 (
    .clk(clk), .rst(rst), .start(start), .halt(halt), .clear(clear), .stall_f(stall_f),
    .event_in(ev), .memwrite(memwrite), .aluout(aluout), .writedata(writedata),
    .running(running2), .cycle_count(cycle2), .stall_count(stall2),
    .event_count(event2), .trace(tif2), .trace_level(level2), .trace_ovf(ovf2));

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model / scoreboard, evaluated mid-cycle for the upcoming edge.
  typedef struct {
    logic [15:0] addr;
    logic [31:0] data;
    logic [31:0] cyc;
    logic [31:0] stl;
  } ent_t;

  ent_t        sbq[$];
  logic [31:0] popped[$];
  int          m_st;
  logic [31:0] m_cyc, m_stl;
  logic [31:0] m_ev[4];
  logic        m_ovf, do_pop, do_push, was_full;
  ent_t        e;

  always @(negedge clk) begin
    if (rst) begin
      m_st = 0; m_cyc = 0; m_stl = 0; m_ovf = 0;
      for (int i = 0; i < 4; i++) m_ev[i] = 0;
      sbq.delete();
    end
    chk("running", running, m_st == 1);
    chk("cycle_count", cycle_count, m_cyc);
    chk("stall_count", stall_count, m_stl);
    for (int i = 0; i < 4; i++) chk("event_count", event_count[i*32 +: 32], m_ev[i]);
    chk("trace_valid", tif.trace_valid, sbq.size() != 0);
    chk("trace_level", level, sbq.size());
    chk("trace_ovf", ovf, m_ovf);
    if (sbq.size() != 0) begin
      chk("head_addr", tif.trace_addr, sbq[0].addr);
      chk("head_data", tif.trace_data, sbq[0].data);
      chk("head_cycle", tif.trace_cycle, sbq[0].cyc);
      chk("head_stall", tif.trace_stall, sbq[0].stl);
    end else begin
      chk("empty_payload", {tif.trace_addr, tif.trace_data, tif.trace_cycle[15:0]}, 64'h0);
    end
    if (!rst && tif.trace_valid && ready && !clear) popped.push_back(tif.trace_data);
    if (!rst) begin
      if (clear) begin
        m_st = 0; m_cyc = 0; m_stl = 0; m_ovf = 0;
        for (int i = 0; i < 4; i++) m_ev[i] = 0;
        sbq.delete();
      end else begin
        do_pop   = (sbq.size() != 0) && ready;
        do_push  = memwrite && (m_st == 1);
        was_full = (sbq.size() == DEPTH);
        e = '{aluout[15:0], writedata, m_cyc, m_stl};
        if (do_pop) void'(sbq.pop_front());
        if (do_push) begin
          if (was_full && !do_pop) m_ovf = 1;
          else sbq.push_back(e);
        end
        if (m_st == 1) begin
          m_cyc = m_cyc + 1;
          m_stl = m_stl + 32'(stall_f);
          for (int i = 0; i < 4; i++) m_ev[i] = m_ev[i] + 32'(ev[i]);
        end
        if (m_st == 0 && start) m_st = 1;
        else if (m_st == 1 && halt) m_st = 2;
      end
    end
  end

  typedef struct {
    logic start, halt, clear, stall;
    logic exp_run;
    int   exp_cyc, exp_stl;
  } vec_t;

  vec_t vecs[11];

  task automatic clear_cycle();
    clear = 1; step(); clear = 0;
  endtask

  task automatic start_cycle();
    start = 1; step(); start = 0;
  endtask

  initial begin
    vecs[0]  = '{0, 0, 0, 0, 0, 0, 0};
    vecs[1]  = '{0, 1, 0, 0, 0, 0, 0};
    vecs[2]  = '{1, 0, 0, 1, 1, 0, 0};
    vecs[3]  = '{0, 0, 0, 1, 1, 1, 1};
    vecs[4]  = '{1, 0, 0, 0, 1, 2, 1};
    vecs[5]  = '{0, 1, 0, 1, 0, 3, 2};
    vecs[6]  = '{1, 0, 0, 0, 0, 3, 2};
    vecs[7]  = '{1, 0, 1, 0, 0, 0, 0};
    vecs[8]  = '{1, 0, 0, 0, 1, 0, 0};
    vecs[9]  = '{0, 1, 1, 0, 0, 0, 0};
    vecs[10] = '{0, 0, 0, 1, 0, 0, 0};

    repeat (10) step();
    chk("reset_running", running, 0);
    chk("reset_valid", tif.trace_valid, 0);
    rst = 0;

    // FSM / counter vector table
    foreach (vecs[k]) begin
      start = vecs[k].start; halt = vecs[k].halt; clear = vecs[k].clear; stall_f = vecs[k].stall;
      step();
      chk("vec_running", running, vecs[k].exp_run);
      chk("vec_cycle", cycle_count, vecs[k].exp_cyc);
      chk("vec_stall", stall_count, vecs[k].exp_stl);
    end
    start = 0; halt = 0; clear = 0; stall_f = 0;

    // 100 RUN cycles, stall every 4th
    clear_cycle();
    start_cycle();
    for (int i = 0; i < 100; i++) begin
      stall_f = (i % 4 == 3);
      ev = {1'b0, 1'(i % 2), 1'(i % 4 == 3), 1'b1};
      halt = (i == 99);
      step();
    end
    halt = 0; stall_f = 0; ev = '0;
    chk("t1_cycle", cycle_count, 100);
    chk("t1_stall", stall_count, 25);
    chk("t1_ev0", event_count[31:0], 100);
    chk("t1_ev1", event_count[63:32], 25);
    chk("t1_ev2", event_count[95:64], 50);
    chk("t1_ev3", event_count[127:96], 0);
    repeat (20) step();
    chk("t1_frozen_cycle", cycle_count, 100);
    chk("t1_frozen_stall", stall_count, 25);
    chk("t1_done", running, 0);

    // single store with stamps 7/2
    clear_cycle();
    start_cycle();
    for (int i = 0; i < 7; i++) begin
      stall_f = (i == 1 || i == 4);
      step();
    end
    stall_f = 0;
    memwrite = 1; aluout = 32'h0000_0054; writedata = 32'h7; ready = 1;
    step();
    memwrite = 0;
    chk("t2_valid", tif.trace_valid, 1);
    chk("t2_addr", tif.trace_addr, 16'h0054);
    chk("t2_data", tif.trace_data, 7);
    chk("t2_cycle", tif.trace_cycle, 7);
    chk("t2_stall", tif.trace_stall, 2);
    step();
    chk("t2_popped", tif.trace_valid, 0);

    // overflow: 9 stores into 8 entries
    ready = 0;
    clear_cycle();
    start_cycle();
    for (int k = 1; k <= 9; k++) begin
      memwrite = 1; aluout = 32'h100 + 32'(k); writedata = 32'(k);
      step();
    end
    memwrite = 0;
    chk("t3_level", level, 8);
    chk("t3_ovf", ovf, 1);
    popped.delete();
    ready = 1;
    repeat (12) step();
    chk("t3_count", popped.size(), 8);
    for (int i = 0; i < 8; i++)
      chk("t3_order", (i < popped.size()) ? popped[i] : 32'hdead, 32'(i + 1));
    chk("t3_ovf_sticky", ovf, 1);

    // full with simultaneous push and pop
    ready = 0;
    clear_cycle();
    chk("t4_ovf_cleared", ovf, 0);
    start_cycle();
    for (int k = 0; k < 8; k++) begin
      memwrite = 1; aluout = 32'h200 + 32'(k); writedata = 32'h10 + 32'(k);
      step();
    end
    memwrite = 1; writedata = 32'hA; ready = 1;
    step();
    memwrite = 0; ready = 0;
    chk("t4_level", level, 8);
    chk("t4_ovf", ovf, 0);
    popped.delete();
    ready = 1;
    repeat (12) step();
    chk("t4_count", popped.size(), 8);
    chk("t4_head", (popped.size() > 0) ? popped[0] : 32'hdead, 32'h11);
    chk("t4_tail", (popped.size() == 8) ? popped[7] : 32'hdead, 32'hA);

    // narrow counters: 20 RUN cycles on a 4-bit instance
    clear_cycle();
    start_cycle();
    repeat (19) step();
    halt = 1; step(); halt = 0;
    chk("t5_cycle32", cycle_count, 20);
`ifdef PERF_SATURATE_EN
    chk("t5_cycle4", cycle2, 4'd15);
`else
    chk("t5_cycle4", cycle2, 4'd4);
`endif

    // asynchronous reset between edges with 3 entries held
    ready = 0;
    clear_cycle();
    start_cycle();
    for (int k = 0; k < 3; k++) begin
      memwrite = 1; writedata = 32'h30 + 32'(k); stall_f = 1;
      step();
    end
    memwrite = 0; stall_f = 0;
    step();
    chk("t6_level_before", level, 3);
    #2 rst = 1;
    #1;
    chk("t6_running", running, 0);
    chk("t6_cycle", cycle_count, 0);
    chk("t6_stall", stall_count, 0);
    chk("t6_valid", tif.trace_valid, 0);
    chk("t6_level", level, 0);
    step();
    rst = 0;
    step();
    chk("t6_idle", running, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
